// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;
  localparam int NUM_REQ     = 2;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } arb_state_e;
endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection: request vector plus last-grant pointer -> one-hot grant.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last,
  output logic [NUM_REQ-1:0] gnt
);
  always_comb begin
    gnt = req;
    // On a tie the requester that was not granted last time wins.
    if (&req) gnt = last ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter with one outstanding access and wait timeout.
// MEM_ARB_RR_EN selects round-robin tie-break; undefined gives fixed priority to requester 0.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_ack,
  output logic [NUM_REQ-1:0]        rsp_err,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [ADDR_W-1:0]         mmu_addr,
  output logic [DATA_W-1:0]         mmu_wdata,
  output logic                      mmu_rd,
  output logic                      mmu_wd,
  input  logic [DATA_W-1:0]         mmu_data,
  input  logic                      mmu_wait,
  input  logic                      mmu_segv,
  output logic                      busy
);
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  arb_state_e         state_q, state_d;
  logic               gnt_q, gnt_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0] pick_gnt;
  logic               pick_idx;
  logic               last_ptr;

  mem_arb_pick u_pick (
    .req  (req_valid),
    .last (last_ptr),
    .gnt  (pick_gnt)
  );

  assign pick_idx = pick_gnt[1];

`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && |req_valid) last_d = pick_idx;
  end

  // Reset to requester 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_q <= 1'b1;
    else          last_q <= last_d;
  end

  assign last_ptr = last_q;
`else
  assign last_ptr = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          gnt_d   = pick_idx;
          we_d    = pick_idx ? req_we[1] : req_we[0];
          addr_d  = pick_idx ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
          wdata_d = pick_idx ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = '0;
        if (mmu_segv) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          err_d   = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!mmu_wait) begin
          rdata_d = we_q ? '0 : mmu_data;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode from state so reset clears them without waiting for an edge.
  assign rsp_ack   = (state_q == RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_err   = rsp_ack & {NUM_REQ{err_q}};
  assign rsp_rdata = rdata_q;
  assign mmu_addr  = addr_q;
  assign mmu_wdata = wdata_q;
  assign mmu_rd    = (state_q == ACCESS) && !we_q;
  assign mmu_wd    = (state_q == ACCESS) && we_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected responses, a monitor pops on rsp_ack.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [1:0]      req_valid, req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      rsp_ack, rsp_err;
  logic [DW-1:0]   rsp_rdata, mmu_wdata, mmu_data;
  logic [AW-1:0]   mmu_addr;
  logic            mmu_rd, mmu_wd, mmu_wait, mmu_segv, busy;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_ack(rsp_ack), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .mmu_addr(mmu_addr), .mmu_wdata(mmu_wdata), .mmu_rd(mmu_rd),
    .mmu_wd(mmu_wd), .mmu_data(mmu_data), .mmu_wait(mmu_wait), .mmu_segv(mmu_segv),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    ack;
    logic [1:0]    err;
    logic [DW-1:0] rdata;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   wd_cnt = 0;
  int   n_pass = 0;
  int   n_tot = 0;
  int   wait_n = 0;
  bit   segv_en = 1'b0;
  logic [7:0] rem = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mmu_wd) wd_cnt <= wd_cnt + 1;

  // Memory model: stall for wait_n cycles after each issue; address 0 faults when enabled.
  always @(posedge clk) begin
    if (mmu_rd || mmu_wd) rem <= 8'(wait_n);
    else if (rem != 8'd0) rem <= rem - 8'd1;
  end
  assign mmu_wait = (rem != 8'd0);
  assign mmu_segv = segv_en && (mmu_addr == '0);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && rsp_ack != 2'b00) begin
      if (sb.size() == 0) chk("unexpected_ack", {62'b0, rsp_ack}, 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_ack", {62'b0, rsp_ack}, {62'b0, e.ack});
        chk("rsp_err", {62'b0, rsp_err}, {62'b0, e.err});
        chk("rsp_rdata", {32'b0, rsp_rdata}, {32'b0, e.rdata});
        chk("ack_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic push(input int r, input logic e_err, input logic [DW-1:0] e_rd, input int at);
    exp_t e;
    e.ack   = (r == 1) ? 2'b10 : 2'b01;
    e.err   = e_err ? e.ack : 2'b00;
    e.rdata = e_rd;
    e.cyc   = at;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  // Called just after a posedge; checks the ACCESS cycle and waits for the ack.
  task automatic single(input int r, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int wn, input bit sg,
                        input logic e_err, input logic [DW-1:0] e_rd, input int lat,
                        input string nm);
    int n, wd0;
    bit got;
    wait_n = wn;
    segv_en = sg;
    req_we[r] = we;
    req_addr[r*AW +: AW] = addr;
    req_wdata[r*DW +: DW] = wdata;
    req_valid[r] = 1'b1;
    n = cyc;
    wd0 = wd_cnt;
    push(r, e_err, e_rd, n + lat);
    @(negedge clk);
    @(negedge clk);
    chk({nm, "_mmu_rd"}, {63'b0, mmu_rd}, {63'b0, !we});
    chk({nm, "_mmu_wd"}, {63'b0, mmu_wd}, {63'b0, we});
    chk({nm, "_mmu_addr"}, {32'b0, mmu_addr}, {32'b0, addr});
    if (we) chk({nm, "_mmu_wdata"}, {32'b0, mmu_wdata}, {32'b0, wdata});
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = rsp_ack[r];
    end
    chk({nm, "_ack_seen"}, {63'b0, got}, 64'd1);
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
    segv_en = 1'b0;
    chk({nm, "_wd_pulses"}, 64'(wd_cnt - wd0), we ? 64'd1 : 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    reset_n = 1'b0;
    req_valid = '0;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;
    mmu_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_ack_err", {60'b0, rsp_ack, rsp_err}, 64'd0);
    chk("rst_mmu_en", {62'b0, mmu_rd, mmu_wd}, 64'd0);
    chk("rst_data", {mmu_addr, rsp_rdata}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    mmu_data = 32'hDEAD_BEEF;
    single(0, 1'b0, 32'h20, 32'h0, 0, 1'b0, 1'b0, 32'hDEAD_BEEF, 3, "rd0");
    repeat (3) @(negedge clk);
    chk("rdata_hold", {32'b0, rsp_rdata}, 64'hDEAD_BEEF);
    chk("idle_busy", {63'b0, busy}, 64'd0);
    @(posedge clk);
    #1;

    single(0, 1'b1, 32'h44, 32'hA5A5_A5A5, 0, 1'b0, 1'b0, 32'h0, 3, "wr0");
    single(1, 1'b1, 32'h0, 32'h1111, 0, 1'b1, 1'b1, 32'h0, 2, "segv1");
    mmu_data = 32'h1234_5678;
    single(1, 1'b0, 32'h80, 32'h0, 3, 1'b0, 1'b0, 32'h1234_5678, 6, "wait3");
    single(0, 1'b0, 32'h90, 32'h0, 255, 1'b0, 1'b1, 32'h0, 18, "timeout");

    // Fields latched at grant: dropping valid and changing addr must not matter.
    mmu_data = 32'hCAFE_F00D;
    wait_n = 0;
    req_we[0] = 1'b0;
    req_addr[0 +: AW] = 32'h40;
    req_valid[0] = 1'b1;
    n = cyc;
    push(0, 1'b0, 32'hCAFE_F00D, n + 3);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    req_addr[0 +: AW] = 32'h99;
    @(negedge clk);
    chk("latch_addr", {32'b0, mmu_addr}, 64'h40);
    chk("latch_rd", {63'b0, mmu_rd}, 64'd1);
    wait_drain(20);

    // Reset in WAIT: abandoned with no ack, outputs cleared at once.
    @(posedge clk);
    #1;
    wait_n = 255;
    req_we[0] = 1'b0;
    req_addr[0 +: AW] = 32'h50;
    req_valid[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("wait_busy", {63'b0, busy}, 64'd1);
    reset_n = 1'b0;
    req_valid = '0;
    #1;
    chk("arst_busy", {63'b0, busy}, 64'd0);
    chk("arst_ack", {62'b0, rsp_ack}, 64'd0);
    chk("arst_mmu_en", {62'b0, mmu_rd, mmu_wd}, 64'd0);
    chk("arst_data", {mmu_addr, rsp_rdata}, 64'd0);
    wait_n = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Continuous write contention from both requesters.
    req_we = 2'b11;
    req_addr = {32'h200, 32'h100};
    req_wdata = {32'hBBBB, 32'hAAAA};
    req_valid = 2'b11;
    n = cyc;
`ifdef MEM_ARB_RR_EN
    push(0, 1'b0, 32'h0, n + 3);
    push(1, 1'b0, 32'h0, n + 7);
    push(0, 1'b0, 32'h0, n + 11);
    push(1, 1'b0, 32'h0, n + 15);
`else
    push(0, 1'b0, 32'h0, n + 3);
    push(0, 1'b0, 32'h0, n + 7);
    push(0, 1'b0, 32'h0, n + 11);
    push(0, 1'b0, 32'h0, n + 15);
`endif
    repeat (16) @(posedge clk);
    #1;
    req_valid = '0;
    wait_drain(10);
    @(negedge clk);
    chk("final_busy", {63'b0, busy}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
